// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package adder_pkg;

    // Encoding 2'd3 is unused and treated as illegal by the FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned ADD_WIDTH = 8;

endpackage

// File: rtl/full_add.sv
// One-bit full-adder cell shared by the serial datapath.
module full_add (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle adder: streams operands LSB-first through one full_add cell,
// chaining the carry through a flip-flop and deserialising the sum.
module bit_serial_adder
    import adder_pkg::*;
#(
    parameter  int unsigned WIDTH = ADD_WIDTH,
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic               r_carry_q;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_fa_sum;
    logic               w_fa_carry;

    full_add u_fa (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .c     (r_carry_q),
        .sum   (w_fa_sum),
        .carry (w_fa_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_res_sh  <= '0;
            r_carry_q <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh    <= a_in;
                        r_b_sh    <= b_in;
                        r_carry_q <= cin;
                        r_cnt     <= '0;
                        r_res_sh  <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_a_sh    <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh    <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_res_sh  <= {w_fa_sum, r_res_sh[WIDTH-1:1]};
                    r_carry_q <= w_fa_carry;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    // Last bit: publish the result straight from the cell outputs.
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_sum   <= {w_fa_sum, r_res_sh[WIDTH-1:1]};
                        r_cout  <= w_fa_carry;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign sum_out = r_sum;
    assign cout    = r_cout;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder at WIDTH=8 and WIDTH=16.
module tb_bit_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        st8, c8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        st16, c16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;

    int n_cmp = 0;
    int n_err = 0;
    logic [16:0] q8[$];
    logic [16:0] q16[$];

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .a_in(a8), .b_in(b8), .cin(c8),
        .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
    );

    bit_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(st16), .a_in(a16), .b_in(b16), .cin(c16),
        .busy(busy16), .done(done16), .sum_out(sum16), .cout(cout16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic obs_busy(input bit w);
        return w ? busy16 : busy8;
    endfunction

    function automatic logic obs_done(input bit w);
        return w ? done16 : done8;
    endfunction

    function automatic logic [16:0] obs_res(input bit w);
        return w ? {cout16, sum16} : {8'h00, cout8, sum8};
    endfunction

    // Drive an accepting request and record its reference result.
    task automatic present(input bit w, input logic [15:0] a, input logic [15:0] b, input logic c);
        if (!w) begin
            st8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; c8 = c;
            q8.push_back(17'({1'b0, a[7:0]} + {1'b0, b[7:0]} + 9'(c)));
        end else begin
            st16 = 1'b1; a16 = a; b16 = b; c16 = c;
            q16.push_back({1'b0, a} + {1'b0, b} + 17'(c));
        end
    endtask

    task automatic start_op(input bit w, input logic [15:0] a, input logic [15:0] b, input logic c);
        @(negedge clk);
        present(w, a, b, c);
    endtask

    // Drop start and scramble operands, which are don't-care after acceptance.
    task automatic release_start(input bit w);
        if (!w) begin
            st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        end else begin
            st16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
        end
    endtask

    task automatic finish_op(input bit w, input int glitch_at, input bit hold);
        int width;
        int bc;
        bit got;
        logic [16:0] exp;
        width = w ? 16 : 8;
        bc = 0;
        got = 1'b0;
        for (int i = 0; i < width + 20 && !got; i++) begin
            @(negedge clk);
            if (!hold && i == 0) release_start(w);
            if (obs_done(w)) begin
                got = 1'b1;
            end else begin
                if (obs_busy(w)) bc++;
                if (glitch_at != 0 && !w && bc == glitch_at) begin
                    st8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
                end else if (glitch_at != 0 && !w && bc == glitch_at + 1) begin
                    st8 = 1'b0;
                end
            end
        end
        check("done_seen", 32'(got), 32'd1);
        if (got) begin
            check("busy_cycles", 32'(bc), 32'(width));
            check("busy_in_done", 32'(obs_busy(w)), 32'd0);
            if (w) begin
                check("sb_nonempty", 32'(q16.size() != 0), 32'd1);
                if (q16.size() != 0) begin
                    exp = q16.pop_front();
                    check("result16", 32'(obs_res(w)), 32'(exp));
                end
            end else begin
                check("sb_nonempty", 32'(q8.size() != 0), 32'd1);
                if (q8.size() != 0) begin
                    exp = q8.pop_front();
                    check("result8", 32'(obs_res(w)), 32'(exp));
                end
            end
        end
        if (!hold) begin
            @(negedge clk);
            check("done_one_cycle", 32'(obs_done(w)), 32'd0);
            check("idle_after_done", 32'(obs_busy(w)), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        st8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
        st16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_res8", 32'(obs_res(1'b0)), 32'd0);
        check("rst_busy16", 32'(busy16), 32'd0);
        check("rst_done16", 32'(done16), 32'd0);
        check("rst_res16", 32'(obs_res(1'b1)), 32'd0);
        rst = 1'b0;

        // Basic add and full carry ripple.
        start_op(1'b0, 16'h005A, 16'h0033, 1'b0);
        finish_op(1'b0, 0, 1'b0);
        start_op(1'b0, 16'h00FF, 16'h0001, 1'b0);
        finish_op(1'b0, 0, 1'b0);
        start_op(1'b0, 16'h00FF, 16'h00FF, 1'b1);
        finish_op(1'b0, 0, 1'b0);

        // Start during RUN must be ignored.
        start_op(1'b0, 16'h0010, 16'h0020, 1'b0);
        finish_op(1'b0, 3, 1'b0);
        repeat (3) @(negedge clk);
        check("no_second_op_busy", 32'(busy8), 32'd0);
        check("no_second_op_res", 32'(obs_res(1'b0)), 32'h030);

        // Back-to-back with start held high; new operands presented in DONE.
        start_op(1'b0, 16'h0022, 16'h0011, 1'b0);
        finish_op(1'b0, 0, 1'b1);
        present(1'b0, 16'h000F, 16'h0001, 1'b0);
        finish_op(1'b0, 0, 1'b1);
        st8 = 1'b0;
        @(negedge clk);
        check("b2b_done_drop", 32'(done8), 32'd0);
        check("b2b_idle", 32'(busy8), 32'd0);

        // Reset in the 4th RUN cycle aborts without a done.
        start_op(1'b0, 16'h0011, 16'h0022, 1'b0);
        void'(q8.pop_back());
        @(negedge clk);
        release_start(1'b0);
        check("abort_running", 32'(busy8), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_res", 32'(obs_res(1'b0)), 32'd0);
        repeat (10) @(negedge clk);
        check("abort_no_done", 32'(done8), 32'd0);
        check("abort_stays_idle", 32'(busy8), 32'd0);
        start_op(1'b0, 16'h007F, 16'h0080, 1'b1);
        finish_op(1'b0, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            start_op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            finish_op(1'b0, 0, 1'b0);
        end
        for (int i = 0; i < 200; i++) begin
            start_op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            finish_op(1'b1, 0, 1'b0);
        end

        check("sb8_drained", 32'(q8.size()), 32'd0);
        check("sb16_drained", 32'(q16.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
